// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM encoding, coin decode and saturating add for the vending controller.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECTED = 3'd1,
      PAYING   = 3'd2,
      DONE     = 3'd3,
      ADMIN    = 3'd4
   } state_t;

   localparam logic [1:0] COIN_1  = 2'b01;
   localparam logic [1:0] COIN_5  = 2'b10;
   localparam logic [1:0] COIN_10 = 2'b11;

   function automatic logic [3:0] coin_value(input logic [1:0] code);
      return code == COIN_1 ? 4'd1 : code == COIN_5 ? 4'd5 : code == COIN_10 ? 4'd10 : 4'd0;
   endfunction

   // Operands are narrow counters zero-extended by the caller, so the 32-bit sum cannot wrap.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] max);
      return (a + b > max) ? max : a + b;
   endfunction

endpackage

// File: rtl/vend_pay_timer.sv
// vend_pay_timer: pay-window down-counter; clr reloads, en counts, expire marks the last window cycle.
module vend_pay_timer #(
   parameter logic [63:0] TIMEOUT_CYC = 64'd3000000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int TW = (TIMEOUT_CYC > 64'd1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= TW'(TIMEOUT_CYC - 64'd1);
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expire = en && cnt == '0;

endmodule

// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: N-slot vending transaction controller (select, pay, change, refund, admin).
// Define VEND_AUDIT_EN to drive the sold_flat/income audit counters; otherwise they read 0.
module vend_txn_ctrl
   import vend_pkg::*;
#(
   parameter int                         N_SLOTS     = 3,
   parameter int                         STOCK_W     = 4,
   parameter int                         QTY_W       = 2,
   parameter int                         PRICE_W     = 4,
   parameter int                         AMT_W       = 8,
   parameter logic [63:0]                TIMEOUT_CYC = 64'd3000000000,
   parameter logic [N_SLOTS*PRICE_W-1:0] PRICE_INIT  = {4'd3, 4'd2, 4'd1},
   localparam int                        SEL_W       = $clog2(N_SLOTS + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sel_valid,
   input  logic [SEL_W-1:0]             sel_slot,
   input  logic [QTY_W-1:0]             sel_qty,
   input  logic                         confirm,
   input  logic                         cancel,
   input  logic                         coin_valid,
   input  logic [1:0]                   coin_code,
   input  logic                         admin_mode,
   input  logic                         restock,
   input  logic [SEL_W-1:0]             restock_slot,
   input  logic [QTY_W-1:0]             restock_qty,
   input  logic                         clear_all,
   input  logic                         price_we,
   input  logic [PRICE_W-1:0]           price_val,
   output logic [2:0]                   state,
   output logic [AMT_W-1:0]             due,
   output logic [AMT_W-1:0]             paid,
   output logic [AMT_W-1:0]             change,
   output logic                         vend_valid,
   output logic [SEL_W-1:0]             vend_slot,
   output logic [QTY_W-1:0]             vend_qty,
   output logic                         txn_ok,
   output logic                         txn_timeout,
   output logic                         err_soldout,
   output logic [N_SLOTS*STOCK_W-1:0]   stock_flat,
   output logic [N_SLOTS*STOCK_W-1:0]   sold_flat,
   output logic [AMT_W-1:0]             income
);

   localparam logic [31:0] STOCK_MAX = 32'(2**STOCK_W - 1);
   localparam logic [31:0] AMT_MAX   = 32'(2**AMT_W - 1);

   state_t             st, nx;
   logic [STOCK_W-1:0] stock [N_SLOTS];
   logic [PRICE_W-1:0] price [N_SLOTS];
   logic [SEL_W-1:0]   slot_r;
   logic [QTY_W-1:0]   qty_r;
   logic               restock_d;
   logic [STOCK_W-1:0] cur_stock;
   logic [PRICE_W-1:0] sel_price;
   logic               sel_hit, sel_ok;
   logic [3:0]         coin_amt;
   logic [AMT_W-1:0]   paid_nx;
   logic               accept, go_pay, soldout, sale, abort, tmo, expire;
   logic               restock_op, clear_op, price_op;

   always_comb begin
      cur_stock = '0;
      sel_price = '0;
      sel_hit   = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (slot_r == SEL_W'(i + 1)) cur_stock = stock[i];
         if (sel_slot == SEL_W'(i + 1)) begin
            sel_price = price[i];
            sel_hit   = 1'b1;
         end
      end
   end

   assign sel_ok     = sel_valid && sel_hit && sel_qty != '0;
   assign coin_amt   = coin_valid ? coin_value(coin_code) : 4'd0;
   assign paid_nx    = AMT_W'(sat_add(32'(paid), 32'(coin_amt), AMT_MAX));
   assign restock_op = st == ADMIN && restock && !restock_d;
   assign clear_op   = st == ADMIN && clear_all;
   assign price_op   = st == ADMIN && price_we;

   vend_pay_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (go_pay),
      .en     (st == PAYING),
      .expire (expire)
   );

   always_ff @(posedge clk) st <= rst ? IDLE : nx;

   // Completing coin beats cancel, which beats timeout.
   always_comb begin
      nx      = st;
      accept  = 1'b0;
      go_pay  = 1'b0;
      soldout = 1'b0;
      sale    = 1'b0;
      abort   = 1'b0;
      tmo     = 1'b0;
      case (st)
         IDLE: begin
            if (admin_mode) nx = ADMIN;
            else if (sel_ok) begin
               nx     = SELECTED;
               accept = 1'b1;
            end
         end
         SELECTED: begin
            if (sel_ok) accept = 1'b1;
            else if (cancel) nx = IDLE;
            else if (confirm) begin
               if (32'(qty_r) <= 32'(cur_stock)) begin
                  nx     = PAYING;
                  go_pay = 1'b1;
               end else soldout = 1'b1;
            end
         end
         PAYING: begin
            if (paid_nx >= due) begin
               nx   = DONE;
               sale = 1'b1;
            end else if (cancel) begin
               nx    = DONE;
               abort = 1'b1;
            end else if (expire) begin
               nx  = DONE;
               tmo = 1'b1;
            end
         end
         DONE:    nx = IDLE;
         ADMIN:   nx = admin_mode ? ADMIN : IDLE;
         default: nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_r      <= '0;
         qty_r       <= '0;
         due         <= '0;
         paid        <= '0;
         change      <= '0;
         vend_valid  <= 1'b0;
         vend_slot   <= '0;
         vend_qty    <= '0;
         txn_ok      <= 1'b0;
         txn_timeout <= 1'b0;
         err_soldout <= 1'b0;
         restock_d   <= 1'b0;
      end else begin
         restock_d  <= restock;
         vend_valid <= sale;
         if (accept) begin
            slot_r      <= sel_slot;
            qty_r       <= sel_qty;
            due         <= AMT_W'(sel_price) * AMT_W'(sel_qty);
            paid        <= '0;
            change      <= '0;
            vend_slot   <= '0;
            vend_qty    <= '0;
            txn_ok      <= 1'b0;
            txn_timeout <= 1'b0;
            err_soldout <= 1'b0;
         end
         if (soldout) err_soldout <= 1'b1;
         if (st == PAYING) paid <= paid_nx;
         if (sale) begin
            change    <= paid_nx - due;
            vend_slot <= slot_r;
            vend_qty  <= qty_r;
            txn_ok    <= 1'b1;
         end
         if (abort || tmo) change <= paid_nx;
         if (tmo) txn_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SLOTS; i++) begin
         if (rst) begin
            stock[i] <= '0;
            price[i] <= PRICE_INIT[i*PRICE_W +: PRICE_W];
         end else begin
            if (clear_op)
               stock[i] <= '0;
            else if (restock_op && restock_slot == SEL_W'(i + 1))
               stock[i] <= STOCK_W'(sat_add(32'(stock[i]), 32'(restock_qty), STOCK_MAX));
            else if (sale && slot_r == SEL_W'(i + 1))
               stock[i] <= stock[i] - STOCK_W'(qty_r);
            if (price_op && restock_slot == SEL_W'(i + 1)) price[i] <= price_val;
         end
      end
   end

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_stock
      assign stock_flat[g*STOCK_W +: STOCK_W] = stock[g];
   end

`ifdef VEND_AUDIT_EN
   logic [STOCK_W-1:0] sold [N_SLOTS];

   always_ff @(posedge clk) begin
      if (rst) income <= '0;
      else if (sale) income <= AMT_W'(sat_add(32'(income), 32'(due), AMT_MAX));
      for (int i = 0; i < N_SLOTS; i++) begin
         if (rst) sold[i] <= '0;
         else if (sale && slot_r == SEL_W'(i + 1)) sold[i] <= sold[i] + STOCK_W'(qty_r);
      end
   end

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_sold
      assign sold_flat[g*STOCK_W +: STOCK_W] = sold[g];
   end
`else
   assign sold_flat = '0;
   assign income    = '0;
`endif

   assign state = st;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb_vend_txn_ctrl: directed scenarios; a negedge monitor scores queued probes and finished transactions.
module tb_vend_txn_ctrl;

   localparam int S_STATE = 0, S_DUE = 1, S_PAID = 2, S_CHANGE = 3, S_STOCK = 4,
                  S_OK = 5, S_TO = 6, S_VV = 7, S_ERR = 8;

   logic        clk = 1'b0, rst = 1'b1;
   logic        sel_valid = 0, confirm = 0, cancel = 0, coin_valid = 0;
   logic [1:0]  sel_slot = 0, sel_qty = 0, coin_code = 0, restock_slot = 0, restock_qty = 0;
   logic        admin_mode = 0, restock = 0, clear_all = 0, price_we = 0;
   logic [3:0]  price_val = 0;
   logic [2:0]  state;
   logic [7:0]  due, paid, change, income;
   logic        vend_valid, txn_ok, txn_timeout, err_soldout;
   logic [1:0]  vend_slot, vend_qty;
   logic [11:0] stock_flat, sold_flat;

   vend_txn_ctrl #(.TIMEOUT_CYC(64'd100)) dut (
      .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_slot(sel_slot), .sel_qty(sel_qty),
      .confirm(confirm), .cancel(cancel), .coin_valid(coin_valid), .coin_code(coin_code),
      .admin_mode(admin_mode), .restock(restock), .restock_slot(restock_slot),
      .restock_qty(restock_qty), .clear_all(clear_all), .price_we(price_we),
      .price_val(price_val), .state(state), .due(due), .paid(paid), .change(change),
      .vend_valid(vend_valid), .vend_slot(vend_slot), .vend_qty(vend_qty), .txn_ok(txn_ok),
      .txn_timeout(txn_timeout), .err_soldout(err_soldout), .stock_flat(stock_flat),
      .sold_flat(sold_flat), .income(income)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       vv;
      logic [1:0] slot;
      logic [1:0] qty;
      logic [7:0] chg;
      logic       ok;
      logic       to;
   } txn_t;

   typedef struct packed {
      logic [7:0]  sig;
      logic [31:0] exp;
   } probe_t;

   txn_t   txq[$];
   probe_t prq[$];
   string  prn[$];
   int     checks = 0, errors = 0;
   bit     fin = 0, mon_done = 0;

   function automatic logic [31:0] sig_val(input logic [7:0] s);
      case (s)
         S_STATE:  return 32'(state);
         S_DUE:    return 32'(due);
         S_PAID:   return 32'(paid);
         S_CHANGE: return 32'(change);
         S_STOCK:  return 32'(stock_flat);
         S_OK:     return 32'(txn_ok);
         S_TO:     return 32'(txn_timeout);
         S_VV:     return 32'(vend_valid);
         S_ERR:    return 32'(err_soldout);
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(negedge clk) begin
      probe_t      p;
      txn_t        t, a;
      string       n;
      logic [31:0] act;
      while (prq.size() != 0) begin
         p   = prq.pop_front();
         n   = prn.pop_front();
         act = sig_val(p.sig);
         checks++;
         if (act !== p.exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, p.exp);
         end
      end
      if (state == 3'd3 || vend_valid) begin
         checks++;
         a = '{vend_valid, vend_slot, vend_qty, change, txn_ok, txn_timeout};
         if (txq.size() == 0) begin
            errors++;
            $display("FAIL txn_unexpected: state %0d vv=%0b with no transaction pending", state, vend_valid);
         end else begin
            t = txq.pop_front();
            if (a !== t || state != 3'd3) begin
               errors++;
               $display("FAIL txn: got st=%0d vv=%0b slot=%0d qty=%0d chg=%0d ok=%0b to=%0b want st=3 vv=%0b slot=%0d qty=%0d chg=%0d ok=%0b to=%0b",
                        state, a.vv, a.slot, a.qty, a.chg, a.ok, a.to, t.vv, t.slot, t.qty, t.chg, t.ok, t.to);
            end
         end
      end
      if (fin && !mon_done) begin
         checks++;
         if (txq.size() != 0) begin
            errors++;
            $display("FAIL txn_missing: %0d expected transactions never completed, want 0", txq.size());
         end
         mon_done = 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name, input int sig, input logic [31:0] exp);
      probe_t p;
      p.sig = 8'(sig);
      p.exp = exp;
      prq.push_back(p);
      prn.push_back(name);
   endtask

   task automatic expect_txn(input logic vv, input logic [1:0] s, input logic [1:0] q,
                             input logic [7:0] c, input logic ok, input logic to);
      txn_t t;
      t = '{vv, s, q, c, ok, to};
      txq.push_back(t);
   endtask

   task automatic sel(input logic [1:0] s, input logic [1:0] q);
      sel_valid = 1; sel_slot = s; sel_qty = q;
      step();
      sel_valid = 0;
   endtask

   task automatic do_confirm();
      confirm = 1; step(); confirm = 0;
   endtask

   task automatic do_cancel();
      cancel = 1; step(); cancel = 0;
   endtask

   task automatic coin(input logic [1:0] c);
      coin_valid = 1; coin_code = c; step(); coin_valid = 0;
   endtask

   task automatic rs(input logic [1:0] s, input logic [1:0] q);
      restock_slot = s; restock_qty = q; restock = 1;
      step();
      restock = 0;
      step();
   endtask

   initial begin
      step(2);
      probe("reset_state", S_STATE, 0);
      probe("reset_due", S_DUE, 0);
      probe("reset_paid", S_PAID, 0);
      probe("reset_change", S_CHANGE, 0);
      probe("reset_stock", S_STOCK, 0);
      probe("reset_ok", S_OK, 0);
      probe("reset_vv", S_VV, 0);
      rst = 0;
      step();
      sel(2'd0, 2'd1);
      probe("ignore_slot0", S_STATE, 0);
      sel(2'd2, 2'd0);
      probe("ignore_qty0", S_STATE, 0);

      admin_mode = 1;
      step();
      probe("admin_enter", S_STATE, 4);
      restock_slot = 1; restock_qty = 2; restock = 1;
      step(3);
      restock = 0;
      step();
      probe("restock_edge_only", S_STOCK, 12'h002);
      rs(2'd2, 2'd3);
      rs(2'd2, 2'd2);
      repeat (4) rs(2'd3, 2'd3);
      probe("restock_12", S_STOCK, 12'hC52);
      rs(2'd3, 2'd3);
      rs(2'd3, 2'd3);
      probe("restock_sat", S_STOCK, 12'hF52);
      restock_slot = 3; price_val = 2; price_we = 1;
      step();
      price_we = 0;
      admin_mode = 0;
      step();
      probe("admin_exit", S_STATE, 0);

      sel(2'd2, 2'd3);
      probe("buy_sel_state", S_STATE, 1);
      probe("buy_due", S_DUE, 6);
      do_confirm();
      probe("buy_pay_state", S_STATE, 2);
      coin(2'b10);
      probe("buy_paid5", S_PAID, 5);
      coin(2'b00);
      probe("coin00_ignored", S_PAID, 5);
      expect_txn(1, 2'd2, 2'd3, 8'd0, 1, 0);
      coin(2'b01);
      step();
      probe("buy_idle", S_STATE, 0);
      probe("buy_stock", S_STOCK, 12'hF22);
      probe("buy_vv_pulse", S_VV, 0);

      sel(2'd1, 2'd1);
      probe("over_due", S_DUE, 1);
      probe("over_ok_cleared", S_OK, 0);
      do_confirm();
      expect_txn(1, 2'd1, 2'd1, 8'd9, 1, 0);
      coin(2'b11);
      step(3);
      probe("over_change_held", S_CHANGE, 9);
      probe("over_ok_held", S_OK, 1);
      probe("over_stock", S_STOCK, 12'hF21);

      sel(2'd1, 2'd2);
      do_confirm();
      probe("sold_err", S_ERR, 1);
      probe("sold_state", S_STATE, 1);
      probe("sold_stock", S_STOCK, 12'hF21);
      do_cancel();
      probe("sel_cancel", S_STATE, 0);

      sel(2'd2, 2'd1);
      probe("cancel_err_cleared", S_ERR, 0);
      do_confirm();
      coin(2'b01);
      expect_txn(0, 2'd0, 2'd0, 8'd1, 0, 0);
      do_cancel();
      step();
      probe("cancel_stock", S_STOCK, 12'hF21);

      sel(2'd3, 2'd3);
      probe("to_due", S_DUE, 6);
      do_confirm();
      coin(2'b01);
      step(98);
      probe("to_still_paying", S_STATE, 2);
      expect_txn(0, 2'd0, 2'd0, 8'd1, 0, 1);
      step();
      step();
      probe("to_flag", S_TO, 1);
      probe("to_stock", S_STOCK, 12'hF21);

      sel(2'd3, 2'd3);
      do_confirm();
      coin(2'b10);
      step(98);
      probe("co_still_paying", S_STATE, 2);
      expect_txn(1, 2'd3, 2'd3, 8'd0, 1, 0);
      coin(2'b01);
      step();
      probe("co_no_timeout", S_TO, 0);
      probe("co_stock", S_STOCK, 12'hC21);

      sel_valid = 1; sel_slot = 2; sel_qty = 1; admin_mode = 1;
      step();
      sel_valid = 0;
      probe("admin_prio", S_STATE, 4);
      probe("admin_prio_due", S_DUE, 6);
      restock_slot = 1; restock_qty = 3; restock = 1; clear_all = 1;
      step();
      restock = 0; clear_all = 0;
      probe("clear_beats_restock", S_STOCK, 0);
      admin_mode = 0;
      step();

      sel(2'd2, 2'd1);
      probe("pre_rst_due", S_DUE, 2);
      rst = 1;
      step();
      rst = 0;
      probe("rst_state", S_STATE, 0);
      probe("rst_due", S_DUE, 0);

      step(2);
      fin = 1;
      wait (mon_done);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
